s2mm_stream_writer: RTL and testbench
=====================================

// Module: s2mm_stream_writer
// PURPOSE
//  S2MM end of the DMA path: AXI-Stream slave that accepts 128-bit beats (8x FP16) from the compute
//  pipeline and writes them into the shared BRAM from out_base. Counterpart of the MM2S BRAM reader.
//  A go_s2mm pulse arms one transfer of byte_len bytes; s2mm_done reports that every beat is committed.
// PARAMETERS
//  ADDR_W   8    BRAM word-address width (one word = DATA_W bits)
//  DATA_W   128  stream/BRAM data width; must be a multiple of 8 (BYTES = DATA_W/8 = 16)
// PORTS
//  clk            in   1        system clock, all logic rising-edge
//  rstn           in   1        asynchronous active-low reset
//  go_s2mm        in   1        1-cycle start pulse; honoured only when idle
//  byte_len       in   32       transfer length in bytes, sampled on go_s2mm
//  out_base       in   ADDR_W   first BRAM word address, sampled on go_s2mm
//  s_axis_tdata   in   DATA_W   stream data
//  s_axis_tvalid  in   1        stream valid
//  s_axis_tlast   in   1        end-of-packet marker
//  s_axis_tready  out  1        stream ready
//  bram_we        out  1        BRAM write enable (registered)
//  bram_wstrb     out  BYTES    byte enables for the write
//  bram_addr      out  ADDR_W   BRAM word address
//  bram_wdata     out  DATA_W   BRAM write data
//  s2mm_busy      out  1        transfer in progress (not IDLE/DONE)
//  s2mm_done      out  1        sticky completion flag, cleared by next accepted go_s2mm
//  s2mm_err       out  1        sticky TLAST-mismatch flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE; tready, bram_we, busy, done, err = 0; wstrb, addr, wdata, counters = 0.
//  States: IDLE -> RUN on go_s2mm; RUN -> DONE after last beat write; DONE -> RUN on next go_s2mm;
//   FLUSH only with TLAST check (below). go_s2mm in RUN/FLUSH is ignored (no relatch, no error).
//  On go: beats = ceil(byte_len/BYTES); rem = byte_len mod BYTES; idx = 0; done, err cleared.
//  byte_len == 0: RUN skipped; done=1 the cycle after go; no bram_we, tready stays 0.
//  RUN: s_axis_tready=1 (registered, rises cycle after go). Beat accepted when tvalid&&tready.
//  Write latency 1: beat accepted at edge T -> bram_we=1, addr=out_base+idx, wdata=tdata during cycle T+1.
//  Address arithmetic is ADDR_W bits, wraps modulo 2^ADDR_W (base 0xFE: FE,FF,00,01).
//  wstrb = all ones except last beat with rem!=0: wstrb = (1<<rem)-1 (LSB byte = lane 0).
//  tready drops the cycle after the last beat is accepted; done=1 one cycle after last bram_we (T+2).
//  tvalid gaps: no write, counters hold; back-to-back beats sustain one write per cycle.
//  Beat counts > 2^ADDR_W wrap over earlier words; caller responsibility, not flagged.
//  Reset mid-transfer: abort immediately, no further writes, done stays 0.
// CONFIGURATION
//  Macro S2MM_TLAST_CHECK_EN:
//   defined: tlast on a beat before the final one -> beat written, err=1, done=1, state DONE (early end).
//    final beat without tlast -> beat written, err=1, state FLUSH: tready=1, beats discarded (no we)
//    until tlast accepted, then done=1. Final beat with tlast -> normal completion, err=0.
//   undefined: tlast ignored; termination by beat count only; s2mm_err tied 0; no FLUSH state.
// STRUCTURE
//  Shared package dma_pkg: DMA_DATA_W=128, DMA_BYTES=16, FSM state encoding
//   (S_IDLE, S_RUN, S_FLUSH, S_DONE), ceil-div/strobe helper function.
//  No sub-module; FSM, beat counter and write register live in this module. The S2MM
//   input skid buffer, if added later, is a separate module axis_skid_buf.
// TESTING
//  1) byte_len=256, out_base=0x80, 16 beats, tvalid toggling 1/0 -> we at 0x80..0x8F in order,
//     wstrb=0xFFFF, data matches, done=1 two cycles after last handshake.
//  2) byte_len=40, base=0x10, 3 beats back-to-back -> writes 0x10,0x11,0x12; last wstrb=0x00FF.
//  3) byte_len=0 go -> done=1 next cycle, bram_we never asserted, tready stays 0.
//  4) base=0xFE, byte_len=64 -> addresses FE,FF,00,01; go pulsed mid-transfer ignored.
//  5) S2MM_TLAST_CHECK_EN: byte_len=64 with tlast on beat 2 -> 2 writes, err=1, done=1;
//     tlast missing on beat 4, arrives on beat 6 -> 4 writes, beats 5-6 dropped, err=1, done=1.
//  6) rstn low after 5 of 16 beats -> all outputs 0 immediately; new go after reset runs cleanly.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA definitions: datapath width, FSM state encoding, length/strobe helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dma_pkg;

  localparam int DMA_DATA_W = 128;
  localparam int DMA_BYTES  = DMA_DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } dma_state_t;

  // Number of unit-sized beats needed to cover num bytes (33 bits so 2^32-1 cannot overflow).
  function automatic logic [32:0] ceil_div(input logic [31:0] num, input logic [31:0] unit);
    logic [32:0] n33;
    logic [32:0] u33;
    n33 = {1'b0, num};
    u33 = {1'b0, unit};
    return (n33 + u33 - 33'd1) / u33;
  endfunction

  // Byte lane enable for the tail beat: rem==0 means the tail beat is full.
  function automatic logic lane_en(input logic [31:0] lane, input logic [31:0] rem);
    return (rem == 32'd0) || (lane < rem);
  endfunction

endpackage

// File: rtl/s2mm_stream_writer.sv
// S2MM writer: AXI-Stream slave that commits 128-bit beats into BRAM starting at out_base.
// Latency: beat accepted at edge T is written (bram_we) in cycle T+1; done rises in T+2.
// Backpressure: tready is registered, high only while a transfer wants beats; no internal buffering.
// Optional macro S2MM_TLAST_CHECK_EN enables TLAST mismatch detection (s2mm_err, FLUSH state).
module s2mm_stream_writer
  import dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                go_s2mm,
  input  logic [31:0]         byte_len,
  input  logic [ADDR_W-1:0]   out_base,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic                bram_we,
  output logic [DATA_W/8-1:0] bram_wstrb,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  output logic                s2mm_busy,
  output logic                s2mm_done,
  output logic                s2mm_err
);

  localparam int BYTES = DATA_W / 8;

  dma_state_t          r_state;
  dma_state_t          w_state_nxt;
  logic                r_tready;
  logic                w_tready_nxt;
  logic                r_we;
  logic [BYTES-1:0]    r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_base;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_done;
  logic                r_last;      // last beat written this cycle, completion due next edge
  logic [32:0]         r_beats;
  logic [32:0]         r_idx;
  logic [31:0]         r_rem;

  logic [32:0]         w_go_beats;
  logic [31:0]         w_go_rem;
  logic                w_accept;
  logic                w_final;
  logic                w_wr;
  logic                w_start;
  logic                w_done_set;
  logic                w_last_set;
  logic [BYTES-1:0]    w_tail_strb;

`ifdef S2MM_TLAST_CHECK_EN
  logic                r_err;
  logic                w_err_set;
`else
  logic                w_unused_tlast;
  assign w_unused_tlast = s_axis_tlast;
`endif

  assign w_go_beats = ceil_div(byte_len, 32'(BYTES));
  assign w_go_rem   = byte_len % 32'(BYTES);
  assign w_accept   = s_axis_tvalid & r_tready;
  assign w_final    = (r_idx == r_beats - 33'd1);
  assign w_wr       = w_accept & (r_state == S_RUN);

  // Byte enables for the final beat of the transfer (all ones when length is a whole number of beats).
  always_comb begin
    w_tail_strb = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_tail_strb[i] = lane_en(32'(i), r_rem);
    end
  end

  // Next-state and control decode; go is only honoured from IDLE/DONE.
  always_comb begin
    w_state_nxt  = r_state;
    w_tready_nxt = r_tready;
    w_start      = 1'b0;
    w_done_set   = 1'b0;
    w_last_set   = 1'b0;
`ifdef S2MM_TLAST_CHECK_EN
    w_err_set    = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (go_s2mm) begin
          w_start = 1'b1;
          if (w_go_beats == 33'd0) begin
            w_state_nxt = S_DONE;
            w_done_set  = 1'b1;
          end else begin
            w_state_nxt  = S_RUN;
            w_tready_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_last) begin
          w_state_nxt = S_DONE;
          w_done_set  = 1'b1;
        end else if (w_accept) begin
`ifdef S2MM_TLAST_CHECK_EN
          if (w_final && s_axis_tlast) begin
            w_tready_nxt = 1'b0;
            w_last_set   = 1'b1;
          end else if (w_final) begin
            // Sender has not closed the packet: keep draining until TLAST shows up.
            w_state_nxt = S_FLUSH;
            w_err_set   = 1'b1;
          end else if (s_axis_tlast) begin
            // Early end of packet: commit this beat and finish short.
            w_tready_nxt = 1'b0;
            w_last_set   = 1'b1;
            w_err_set    = 1'b1;
          end
`else
          if (w_final) begin
            w_tready_nxt = 1'b0;
            w_last_set   = 1'b1;
          end
`endif
        end
      end
      S_FLUSH: begin
`ifdef S2MM_TLAST_CHECK_EN
        if (w_accept && s_axis_tlast) begin
          w_tready_nxt = 1'b0;
          w_state_nxt  = S_DONE;
          w_done_set   = 1'b1;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transfer parameters, beat counter, write register and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tready <= 1'b0;
      r_we     <= 1'b0;
      r_wstrb  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_base   <= '0;
      r_done   <= 1'b0;
      r_last   <= 1'b0;
      r_beats  <= '0;
      r_idx    <= '0;
      r_rem    <= '0;
    end else begin
      r_tready <= w_tready_nxt;
      r_we     <= 1'b0;
      if (w_start) begin
        r_beats <= w_go_beats;
        r_rem   <= w_go_rem;
        r_base  <= out_base;
        r_idx   <= '0;
        r_last  <= 1'b0;
        r_done  <= w_done_set;
      end else begin
        r_last <= w_last_set;
        if (w_done_set) begin
          r_done <= 1'b1;
        end
      end
      if (w_wr) begin
        r_we    <= 1'b1;
        r_addr  <= r_base + r_idx[ADDR_W-1:0];
        r_wdata <= s_axis_tdata;
        r_wstrb <= w_final ? w_tail_strb : '1;
        r_idx   <= r_idx + 33'd1;
      end
    end
  end

`ifdef S2MM_TLAST_CHECK_EN
  // Sticky TLAST mismatch flag, cleared when a new transfer starts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end
  assign s2mm_err = r_err;
`else
  assign s2mm_err = 1'b0;
`endif

  assign s_axis_tready = r_tready;
  assign bram_we       = r_we;
  assign bram_wstrb    = r_wstrb;
  assign bram_addr     = r_addr;
  assign bram_wdata    = r_wdata;
  assign s2mm_done     = r_done;
  assign s2mm_busy     = (r_state == S_RUN) || (r_state == S_FLUSH);

endmodule

// File: tb/tb_s2mm_stream_writer.sv
// Bench for s2mm_stream_writer: scoreboard of expected BRAM writes plus per-scenario checks.
// Latency: n/a.
// Backpressure: stimulus honours tready; every wait is bounded.
module tb_s2mm_stream_writer;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         go_s2mm = 1'b0;
  logic [31:0]  byte_len = '0;
  logic [7:0]   out_base = '0;
  logic [127:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic         bram_we;
  logic [15:0]  bram_wstrb;
  logic [7:0]   bram_addr;
  logic [127:0] bram_wdata;
  logic         s2mm_busy;
  logic         s2mm_done;
  logic         s2mm_err;

  s2mm_stream_writer #(.ADDR_W(8), .DATA_W(128)) dut (
    .clk(clk), .rstn(rstn), .go_s2mm(go_s2mm), .byte_len(byte_len), .out_base(out_base),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .bram_we(bram_we), .bram_wstrb(bram_wstrb),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .s2mm_busy(s2mm_busy),
    .s2mm_done(s2mm_done), .s2mm_err(s2mm_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   addr;
    logic [15:0]  strb;
    logic [127:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;
  int  checks = 0;
  int  fails = 0;
  int  n_writes = 0;

  // Scoreboard: every BRAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (rstn && bram_we) begin
      n_writes++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%h strb=%h, required no write", bram_addr, bram_wstrb);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bram_addr, bram_wstrb, bram_wdata} !== mon_exp) begin
          fails++;
          $display("FAIL bram_write: got addr=%h strb=%h data=%h, required addr=%h strb=%h data=%h",
                   bram_addr, bram_wstrb, bram_wdata, mon_exp.addr, mon_exp.strb, mon_exp.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  task automatic pulse_go(input logic [31:0] len, input logic [7:0] base);
    @(posedge clk); #1;
    go_s2mm = 1'b1; byte_len = len; out_base = base;
    @(posedge clk); #1;
    go_s2mm = 1'b0;
  endtask

  // Offers n_send beats; the first n_wr accepted are expected in BRAM at base+k.
  task automatic send_beats(input int n_send, input int n_wr, input int n_tot, input int rem,
                            input logic [7:0] base, input int tlast_at, input bit gaps,
                            output bit timeout, output int ncyc);
    int k;
    bit phase;
    logic [127:0] cur;
    logic [15:0] s;
    wr_t e;
    k = 0; phase = 1'b0; timeout = 1'b0; ncyc = 0;
    cur = {$urandom, $urandom, $urandom, $urandom};
    while (k < n_send && !timeout) begin
      @(posedge clk); #1;
      s_axis_tdata  = cur;
      s_axis_tlast  = (k + 1 == tlast_at);
      s_axis_tvalid = !(gaps && phase);
      phase = !phase;
      @(negedge clk);
      ncyc++;
      if (s_axis_tvalid && s_axis_tready) begin
        if (k < n_wr) begin
          s = (rem != 0 && k == n_tot - 1) ? 16'((32'd1 << rem) - 32'd1) : 16'hFFFF;
          e = {base + 8'(k), s, cur};
          exp_q.push_back(e);
        end
        k++;
        cur = {$urandom, $urandom, $urandom, $urandom};
      end
      if (ncyc > 200) timeout = 1'b1;
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #1;
    checks++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b, required 0", s_axis_tready); end
    checks++; if (bram_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b, required 0", bram_we); end
    checks++; if (s2mm_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", s2mm_busy); end
    checks++; if (s2mm_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", s2mm_done); end
    checks++; if (s2mm_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, required 0", s2mm_err); end
    checks++; if ({bram_wstrb, bram_addr} !== 24'h0) begin fails++; $display("FAIL reset_strb_addr: got %h/%h, required 0/0", bram_wstrb, bram_addr); end
    checks++; if (bram_wdata !== 128'h0) begin fails++; $display("FAIL reset_wdata: got %h, required 0", bram_wdata); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b0 || s2mm_busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset: got tready=%b busy=%b, required 0/0", s_axis_tready, s2mm_busy); end
  endtask

  task automatic test_zero_len();
    int w0;
    bit seen_tr;
    w0 = n_writes; seen_tr = 1'b0;
    pulse_go(32'd0, 8'h33);
    @(negedge clk);
    checks++; if (s2mm_done !== 1'b1) begin fails++; $display("FAIL zero_len_done: got %b, required 1", s2mm_done); end
    checks++; if (s2mm_busy !== 1'b0) begin fails++; $display("FAIL zero_len_busy: got %b, required 0", s2mm_busy); end
    if (s_axis_tready) seen_tr = 1'b1;
    repeat (4) begin @(negedge clk); if (s_axis_tready) seen_tr = 1'b1; end
    checks++; if (seen_tr !== 1'b0) begin fails++; $display("FAIL zero_len_tready: got high, required stays 0"); end
    checks++; if (n_writes != w0) begin fails++; $display("FAIL zero_len_writes: got %0d, required 0", n_writes - w0); end
  endtask

  task automatic test_gapped();
    int w0, nc;
    bit to;
    w0 = n_writes;
    pulse_go(32'd256, 8'h80);
    @(negedge clk);
    checks++; if (s2mm_busy !== 1'b1 || s_axis_tready !== 1'b1 || s2mm_done !== 1'b0) begin fails++; $display("FAIL gapped_start: got busy=%b tready=%b done=%b, required 1/1/0", s2mm_busy, s_axis_tready, s2mm_done); end
    send_beats(16, 16, 16, 0, 8'h80, 16, 1'b1, to, nc);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL gapped_timeout: beats not accepted within budget, got %0d cycles", nc); end
    @(negedge clk);
    checks++; if (s2mm_done !== 1'b0 || s_axis_tready !== 1'b0 || bram_we !== 1'b1) begin fails++; $display("FAIL gapped_last_cycle: got done=%b tready=%b we=%b, required 0/0/1", s2mm_done, s_axis_tready, bram_we); end
    @(negedge clk);
    checks++; if (s2mm_done !== 1'b1 || s2mm_busy !== 1'b0 || s2mm_err !== 1'b0) begin fails++; $display("FAIL gapped_done: got done=%b busy=%b err=%b, required 1/0/0", s2mm_done, s2mm_busy, s2mm_err); end
    checks++; if (n_writes - w0 != 16 || exp_q.size() != 0) begin fails++; $display("FAIL gapped_count: got %0d writes, %0d pending, required 16/0", n_writes - w0, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int w0, nc;
    bit to;
    w0 = n_writes;
    pulse_go(32'd40, 8'h10);
    send_beats(3, 3, 3, 8, 8'h10, 3, 1'b0, to, nc);
    checks++; if (to !== 1'b0 || nc != 3) begin fails++; $display("FAIL b2b_rate: got %0d cycles for 3 beats, required 3", nc); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (s2mm_done !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b, required 1", s2mm_done); end
    checks++; if (n_writes - w0 != 3 || exp_q.size() != 0) begin fails++; $display("FAIL b2b_count: got %0d writes, %0d pending, required 3/0", n_writes - w0, exp_q.size()); end
    checks++; if (bram_wstrb !== 16'h00FF) begin fails++; $display("FAIL b2b_tail_strb: got %h, required 00ff", bram_wstrb); end
  endtask

  task automatic test_wrap_and_ignored_go();
    int w0, nc;
    bit to;
    w0 = n_writes;
    pulse_go(32'd64, 8'hFE);
    fork
      send_beats(4, 4, 4, 0, 8'hFE, 4, 1'b0, to, nc);
      begin
        @(posedge clk); #1;
        go_s2mm = 1'b1; byte_len = 32'd16; out_base = 8'h40;
        @(posedge clk); #1;
        go_s2mm = 1'b0;
      end
    join
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL wrap_timeout: got %0d cycles", nc); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (s2mm_done !== 1'b1 || s2mm_busy !== 1'b0) begin fails++; $display("FAIL wrap_done: got done=%b busy=%b, required 1/0", s2mm_done, s2mm_busy); end
    checks++; if (n_writes - w0 != 4 || exp_q.size() != 0) begin fails++; $display("FAIL wrap_count: got %0d writes, %0d pending, required 4/0", n_writes - w0, exp_q.size()); end
    checks++; if (bram_addr !== 8'h01) begin fails++; $display("FAIL wrap_last_addr: got %h, required 01", bram_addr); end
  endtask

`ifdef S2MM_TLAST_CHECK_EN
  task automatic test_tlast_check();
    int w0, nc;
    bit to;
    w0 = n_writes;
    pulse_go(32'd64, 8'h50);
    send_beats(2, 2, 4, 0, 8'h50, 2, 1'b0, to, nc);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL early_tlast_timeout: got %0d cycles", nc); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (s2mm_done !== 1'b1 || s2mm_err !== 1'b1 || s_axis_tready !== 1'b0) begin fails++; $display("FAIL early_tlast_flags: got done=%b err=%b tready=%b, required 1/1/0", s2mm_done, s2mm_err, s_axis_tready); end
    checks++; if (n_writes - w0 != 2 || exp_q.size() != 0) begin fails++; $display("FAIL early_tlast_count: got %0d writes, required 2", n_writes - w0); end
    w0 = n_writes;
    pulse_go(32'd64, 8'h60);
    @(negedge clk);
    checks++; if (s2mm_err !== 1'b0 || s2mm_done !== 1'b0) begin fails++; $display("FAIL go_clears_flags: got err=%b done=%b, required 0/0", s2mm_err, s2mm_done); end
    send_beats(6, 4, 4, 0, 8'h60, 6, 1'b0, to, nc);
    checks++; if (to !== 1'b0) begin fails++; $display("FAIL late_tlast_timeout: got %0d cycles", nc); end
    @(negedge clk);
    checks++; if (s2mm_done !== 1'b1 || s2mm_err !== 1'b1 || s2mm_busy !== 1'b0) begin fails++; $display("FAIL late_tlast_flags: got done=%b err=%b busy=%b, required 1/1/0", s2mm_done, s2mm_err, s2mm_busy); end
    checks++; if (n_writes - w0 != 4 || exp_q.size() != 0) begin fails++; $display("FAIL late_tlast_count: got %0d writes, required 4", n_writes - w0); end
  endtask
`endif

  task automatic test_reset_mid();
    int w0, nc;
    bit to;
    bit seen;
    pulse_go(32'd256, 8'h00);
    send_beats(5, 5, 16, 0, 8'h00, 0, 1'b0, to, nc);
    @(negedge clk);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {4{32'hDEADBEEF}};
    #1 rstn = 1'b0;
    #1;
    checks++; if ({s_axis_tready, bram_we, s2mm_busy, s2mm_done, s2mm_err} !== 5'b0) begin fails++; $display("FAIL midreset_flags: got tready=%b we=%b busy=%b done=%b err=%b, required all 0", s_axis_tready, bram_we, s2mm_busy, s2mm_done, s2mm_err); end
    checks++; if ({bram_wstrb, bram_addr} !== 24'h0 || bram_wdata !== 128'h0) begin fails++; $display("FAIL midreset_data: got strb=%h addr=%h, required 0/0", bram_wstrb, bram_addr); end
    checks++; if (exp_q.size() != 0 || to !== 1'b0) begin fails++; $display("FAIL midreset_committed: got %0d pending, required 0", exp_q.size()); end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    w0 = n_writes; seen = 1'b0;
    repeat (3) begin @(negedge clk); if (s_axis_tready || s2mm_done) seen = 1'b1; end
    s_axis_tvalid = 1'b0;
    checks++; if (seen !== 1'b0 || n_writes != w0) begin fails++; $display("FAIL post_reset_idle: got activity (%0d writes), required none", n_writes - w0); end
    pulse_go(32'd32, 8'h20);
    send_beats(2, 2, 2, 0, 8'h20, 2, 1'b0, to, nc);
    @(negedge clk);
    @(negedge clk);
    checks++; if (s2mm_done !== 1'b1 || n_writes - w0 != 2 || exp_q.size() != 0) begin fails++; $display("FAIL post_reset_run: got done=%b writes=%0d, required 1/2", s2mm_done, n_writes - w0); end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_gapped();
    test_back_to_back();
    test_wrap_and_ignored_go();
`ifdef S2MM_TLAST_CHECK_EN
    test_tlast_check();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL final_queue: got %0d pending writes, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
